conv_window_gen: RTL

//  Parametrised sliding-window generator for the conv layer: accepts a raster pixel stream, buffers K-1 rows
//  and emits a flattened KxK window per output position, with configurable stride and valid/ready backpressure.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_line_buf.sv | 42 ++++
 rtl/conv_window_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and geometry helpers for the conv-layer sliding-window generator.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int out_w(input int img_w, input int k, input int stride);
    return (img_w - k) / stride + 1;
  endfunction

  function automatic int out_h(input int img_h, input int k, input int stride);
    return (img_h - k) / stride + 1;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Chained (K-1)-row line buffer: row 0 holds the previous image row, row j the row j+1 above current.
// Reads are registered and prefetched one column ahead so the column is ready when its pixel arrives.
module conv_line_buf #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int ROWS   = 6,
  parameter int AW     = 5
) (
  input  logic                   clk_i,
  input  logic                   en_i,
  input  logic [AW-1:0]          wr_col_i,
  input  logic [AW-1:0]          rd_col_i,
  input  logic [DATA_W-1:0]      din_i,
  output logic [ROWS*DATA_W-1:0] col_o
);

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [DATA_W-1:0] mem_q [IMG_W];
      logic [DATA_W-1:0] rd_q;
      logic [DATA_W-1:0] wr_data;

      // Each row is refilled with what the row below held at this column (read-before-write).
      if (gi == 0) begin : g_head
        assign wr_data = din_i;
      end else begin : g_link
        assign wr_data = col_o[(gi-1)*DATA_W +: DATA_W];
      end

      always_ff @(posedge clk_i) begin
        if (en_i) begin
          mem_q[wr_col_i] <= wr_data;
          rd_q            <= mem_q[rd_col_i];
        end
      end

      assign col_o[gi*DATA_W +: DATA_W] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator: raster pixel stream in, strided flattened windows out with
// valid/ready backpressure, frame markers and filter-pass tagging.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = 7,
  parameter int STRIDE = 1,
  parameter int N_FILT = 5,
  localparam int FW    = (N_FILT > 1) ? clog2(N_FILT) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_W-1:0]     pix_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  input  logic                  pix_sof_i,
  output logic [K*K*DATA_W-1:0] win_data_o,
  output logic                  win_valid_o,
  input  logic                  win_ready_i,
  output logic                  win_sof_o,
  output logic                  win_sol_o,
  output logic                  win_eof_o,
  output logic [FW-1:0]         filt_idx_o,
  output logic                  pass_last_o,
  output logic                  err_o
);

  localparam int CW       = clog2(IMG_W);
  localparam int RW       = clog2(IMG_H);
  localparam int WIN_W    = K * K * DATA_W;
  localparam int LAST_COL = K - 1 + (out_w(IMG_W, K, STRIDE) - 1) * STRIDE;
  localparam int LAST_ROW = K - 1 + (out_h(IMG_H, K, STRIDE) - 1) * STRIDE;

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [FW-1:0]     filt_q, filt_d;
  logic              seen_sof_q, pass_last_q, err_q;
  logic              win_valid_q, win_sof_q, win_sol_q, win_eof_q;
  logic [WIN_W-1:0]  win_q, win_d;

  logic              accept, take, drop, emit;
  logic [CW-1:0]     pix_col, nxt_col;
  logic [RW-1:0]     pix_row;
  logic              col_last, row_last;
  logic [(K-1)*DATA_W-1:0] lb_col;
  logic [K*DATA_W-1:0]     col_vec;

  assign pix_ready_o = !win_valid_q || win_ready_i;
  assign accept      = pix_valid_i && pix_ready_o;
  assign take        = accept && (pix_sof_i || state_q == FILL || state_q == RUN);
  assign drop        = accept && !pix_sof_i && (state_q == IDLE || state_q == DONE);

  // An accepted sof always re-anchors the pixel at (0,0), even mid-frame.
  assign pix_col  = pix_sof_i ? '0 : col_q;
  assign pix_row  = pix_sof_i ? '0 : row_q;
  assign col_last = (pix_col == CW'(IMG_W - 1));
  assign row_last = (pix_row == RW'(IMG_H - 1));
  assign nxt_col  = col_last ? '0 : pix_col + CW'(1);

  assign emit = take && !pix_sof_i && state_q == RUN
             && (col_q >= CW'(K - 1)) && (row_q >= RW'(K - 1))
             && (((col_q - CW'(K - 1)) % CW'(STRIDE)) == '0)
             && (((row_q - RW'(K - 1)) % RW'(STRIDE)) == '0);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (take) begin
      col_d = nxt_col;
      row_d = col_last ? pix_row + RW'(1) : pix_row;
      if (col_last && row_last) begin
        state_d = DONE;
        col_d   = '0;
        row_d   = '0;
      end else if (col_last && pix_row == RW'(K - 2)) begin
        state_d = RUN;
      end else if (pix_sof_i) begin
        state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  conv_line_buf #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .ROWS   (K - 1),
    .AW     (CW)
  ) u_line_buf (
    .clk_i    (clk_i),
    .en_i     (take),
    .wr_col_i (pix_col),
    .rd_col_i (nxt_col),
    .din_i    (pix_i),
    .col_o    (lb_col)
  );

  // Window row r: oldest columns at low addresses, the newly arrived column enters at the right.
  genvar gi, gj;
  generate
    for (gi = 0; gi < K; gi++) begin : g_wrow
      if (gi == K - 1) begin : g_cur
        assign col_vec[gi*DATA_W +: DATA_W] = pix_i;
      end else begin : g_buf
        assign col_vec[gi*DATA_W +: DATA_W] = lb_col[(K-2-gi)*DATA_W +: DATA_W];
      end
      for (gj = 0; gj < K; gj++) begin : g_wcol
        if (gj < K - 1) begin : g_shift
          assign win_d[(gi*K+gj)*DATA_W +: DATA_W] = win_q[(gi*K+gj+1)*DATA_W +: DATA_W];
        end else begin : g_load
          assign win_d[(gi*K+gj)*DATA_W +: DATA_W] = col_vec[gi*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

  // The shift register doubles as the output data register: no pixel enters while a window is held.
  always_ff @(posedge clk_i) begin
    if (take) win_q <= win_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_valid_q <= 1'b0;
      win_sof_q   <= 1'b0;
      win_sol_q   <= 1'b0;
      win_eof_q   <= 1'b0;
    end else if (emit) begin
      win_valid_q <= 1'b1;
      win_sof_q   <= (col_q == CW'(K - 1)) && (row_q == RW'(K - 1));
      win_sol_q   <= (col_q == CW'(K - 1));
      win_eof_q   <= (col_q == CW'(LAST_COL)) && (row_q == RW'(LAST_ROW));
    end else if (win_ready_i) begin
      win_valid_q <= 1'b0;
      win_sof_q   <= 1'b0;
      win_sol_q   <= 1'b0;
      win_eof_q   <= 1'b0;
    end
  end

  assign filt_d = !seen_sof_q ? filt_q :
                  (filt_q == FW'(N_FILT - 1)) ? '0 : filt_q + FW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q      <= '0;
      seen_sof_q  <= 1'b0;
      pass_last_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept && pix_sof_i) begin
      filt_q      <= filt_d;
      seen_sof_q  <= 1'b1;
      pass_last_q <= (filt_d == FW'(N_FILT - 1));
      err_q       <= 1'b0;
    end else if (drop) begin
      err_q       <= 1'b1;
    end
  end

  assign win_data_o  = win_q;
  assign win_valid_o = win_valid_q;
  assign win_sof_o   = win_sof_q;
  assign win_sol_o   = win_sol_q;
  assign win_eof_o   = win_eof_q;
  assign filt_idx_o  = filt_q;
  assign pass_last_o = pass_last_q;
  assign err_o       = err_q;

endmodule
